// File: rtl/data_memory_pipe.sv
// data_memory_pipe: pipelined data memory with valid/ready requests,
// RD_LAT-deep read pipeline and a hardware zero-fill pass after reset.
// Optional feature macro: DMEM_PARITY_EN (per-word even parity + PERR output).
module data_memory_pipe #(
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 6,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic          REQ_WE,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] WD,
    output logic          RSP_VALID,
    output logic [DW-1:0] RD,
    output logic          BUSY
`ifdef DMEM_PARITY_EN
    ,
    output logic          PERR
`endif
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned FW    = AW + 1;
`ifdef DMEM_PARITY_EN
    localparam int unsigned MW    = DW + 1;
`else
    localparam int unsigned MW    = DW;
`endif

    // Reject unsupported read latencies at elaboration
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("data_memory_pipe: RD_LAT must be in 1..4");
    end

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            init_we;

    logic            wr_acc;
    logic            rd_acc;
    logic [MW-1:0]   wr_word;
    logic [MW-1:0]   rd_word;

    logic [MW-1:0]   mem [DEPTH];

    logic [RD_LAT-1:0] vld_q;
    logic [DW-1:0]     dat_q [RD_LAT];
`ifdef DMEM_PARITY_EN
    logic [RD_LAT-1:0] perr_q;
`endif

    assign wr_acc  = REQ_VALID & ready_q & REQ_WE;
    assign rd_acc  = REQ_VALID & ready_q & ~REQ_WE;
    assign rd_word = mem[A];
`ifdef DMEM_PARITY_EN
    assign wr_word = {^WD, WD};
`else
    assign wr_word = WD;
`endif

    // FSM state, fill counter and handshake/status registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= INIT;
            fill_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Next state: walk the whole array once, then stay in RUN until reset
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        init_we = 1'b0;
        case (state_q)
            INIT: begin
                init_we = 1'b1;
                fill_d  = fill_q + FW'(1);
                if (fill_q == FW'(DEPTH - 1)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Storage array: zero-fill during INIT, accepted writes in RUN (not reset)
    always_ff @(posedge CLK) begin
        if (init_we) begin
            mem[fill_q[AW-1:0]] <= '0;
        end else if (wr_acc) begin
            mem[A] <= wr_word;
        end
    end

    // Read pipeline; data stages only advance behind a valid so RD holds
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                dat_q[i] <= '0;
            end
`ifdef DMEM_PARITY_EN
            perr_q <= '0;
`endif
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                dat_q[0] <= rd_word[DW-1:0];
            end
`ifdef DMEM_PARITY_EN
            perr_q[0] <= rd_acc & (^rd_word);
`endif
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
`ifdef DMEM_PARITY_EN
                perr_q[i] <= perr_q[i-1];
`endif
            end
        end
    end

    assign REQ_READY = ready_q;
    assign BUSY      = busy_q;
    assign RSP_VALID = vld_q[RD_LAT-1];
    assign RD        = dat_q[RD_LAT-1];
`ifdef DMEM_PARITY_EN
    assign PERR      = perr_q[RD_LAT-1];
`endif

endmodule
